// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage -- single-entry write-back stage.
//
// Takes one retiring instruction bundle from the LSU stage. On the following
// cycle it presents the GPR, CSR and trap writes unless the register/CSR
// files signal a stall. A trap entry (irqW) writes mepc/mcause and redirects
// the IFU to mtvec. It also counts retired instructions.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   handshake with the LSU stage
//   rd1W .. MemRW       32-bit data bundle (rs1 value, ALU result, CSR read
//                       value, pc, immediate, pc+4, load data)
//   irqW, RegwriteDW,   control bundle: trap flag, GPR write-data select,
//   CSRWriteDW          CSR write mode
//   rdW, csr_addrW      destination GPR / CSR
//   wb_stall            register/CSR file cannot take a write this cycle
//   rf_*                GPR write port
//   csr_*               general CSR write port
//   mepc_*, mcause_*    dedicated trap CSR write ports
//   redirect_*          trap redirect to the IFU
//   commit_valid/pc     one-cycle retire pulse and its pc
//   instret             retired-instruction counter
// ---------------------------------------------------------------------------
module wb_stage #(
  parameter logic [31:0] MCAUSE_ECALL = 32'd11,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      rd1W,
  input  logic [31:0]      aluresultW,
  input  logic [31:0]      crd1W,
  input  logic [31:0]      pcW,
  input  logic [31:0]      immextW,
  input  logic [31:0]      pc_plus_4W,
  input  logic [31:0]      MemRW,
  input  logic             irqW,
  input  logic [2:0]       RegwriteDW,
  input  logic [1:0]       CSRWriteDW,
  input  logic [4:0]       rdW,
  input  logic [11:0]      csr_addrW,
  input  logic             wb_stall,
  output logic             rf_wen,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             csr_wen,
  output logic [11:0]      csr_waddr,
  output logic [31:0]      csr_wdata,
  output logic             mepc_wen,
  output logic [31:0]      mepc_wdata,
  output logic             mcause_wen,
  output logic [31:0]      mcause_wdata,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             commit_valid,
  output logic [31:0]      commit_pc,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t r_state;
  state_t w_state_next;

  logic [31:0]      r_rd1;
  logic [31:0]      r_alu;
  logic [31:0]      r_crd1;
  logic [31:0]      r_pc;
  logic [31:0]      r_imm;
  logic [31:0]      r_pc4;
  logic [31:0]      r_memr;
  logic             r_irq;
  logic [2:0]       r_rw;
  logic [1:0]       r_csrw;
  logic [4:0]       r_rd;
  logic [11:0]      r_csra;
  logic [CNT_W-1:0] r_instret;

  logic w_capture;
  logic w_commit;
  logic w_rf_sel;

  // The entry can be overwritten whenever it is leaving this cycle, so a
  // non-stalled FULL stage still accepts (back-to-back, no bubble).
  assign in_ready  = (r_state == S_EMPTY) | ~wb_stall;
  assign w_capture = in_valid & in_ready;
  assign w_commit  = (r_state == S_FULL) & ~wb_stall;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: a capture always leaves the entry FULL, even when the
  // old entry commits on the same edge.
  always_comb begin
    w_state_next = r_state;
    if (w_capture) begin
      w_state_next = S_FULL;
    end else if (w_commit) begin
      w_state_next = S_EMPTY;
    end
  end

  // Entry storage. Cleared on reset so that every data output reads 0 while
  // reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd1  <= '0;
      r_alu  <= '0;
      r_crd1 <= '0;
      r_pc   <= '0;
      r_imm  <= '0;
      r_pc4  <= '0;
      r_memr <= '0;
      r_irq  <= 1'b0;
      r_rw   <= '0;
      r_csrw <= '0;
      r_rd   <= '0;
      r_csra <= '0;
    end else if (w_capture) begin
      r_rd1  <= rd1W;
      r_alu  <= aluresultW;
      r_crd1 <= crd1W;
      r_pc   <= pcW;
      r_imm  <= immextW;
      r_pc4  <= pc_plus_4W;
      r_memr <= MemRW;
      r_irq  <= irqW;
      r_rw   <= RegwriteDW;
      r_csrw <= CSRWriteDW;
      r_rd   <= rdW;
      r_csra <= csr_addrW;
    end
  end

  // Retired-instruction counter, wraps naturally at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instret <= '0;
    end else if (w_commit) begin
      r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign instret = r_instret;

  // Write-port outputs
  always_comb begin
    w_rf_sel       = 1'b1;
    rf_wdata       = 32'd0;
    csr_wdata      = r_rd1;
    rf_wen         = 1'b0;
    csr_wen        = 1'b0;
    mepc_wen       = 1'b0;
    mcause_wen     = 1'b0;
    mcause_wdata   = 32'd0;
    redirect_valid = 1'b0;
    commit_valid   = 1'b0;

    case (r_rw)
      3'b001:  rf_wdata = r_alu;
      3'b010:  rf_wdata = r_memr;
      3'b011:  rf_wdata = r_pc4;
      3'b100:  rf_wdata = r_imm;
      3'b101:  rf_wdata = r_crd1;
      default: w_rf_sel = 1'b0;
    endcase

    // Mode 10 is the set-bits form: old CSR value OR rs1.
    if (r_csrw == 2'b10) begin
      csr_wdata = r_crd1 | r_rd1;
    end

    if (w_commit) begin
      commit_valid = 1'b1;
      // x0 is hard-wired zero, so its writes are dropped here.
      rf_wen       = w_rf_sel & (r_rd != 5'd0);
      if (r_irq) begin
        // A trap entry takes the trap CSRs instead of the general CSR port;
        // crd1 carries mtvec for this entry.
        mepc_wen       = 1'b1;
        mcause_wen     = 1'b1;
        mcause_wdata   = MCAUSE_ECALL;
        redirect_valid = 1'b1;
      end else begin
        csr_wen = (r_csrw == 2'b01) | (r_csrw == 2'b10);
      end
    end
  end

  assign rf_waddr    = r_rd;
  assign csr_waddr   = r_csra;
  assign mepc_wdata  = r_pc;
  assign redirect_pc = r_crd1;
  assign commit_pc   = r_pc;

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage -- scoreboard bench for wb_stage.
// Stimulus pushes the hand-computed expected commit into a queue; a monitor
// on the falling edge pops and compares whenever commit_valid is seen.
// The counter is built 3 bits wide so the wrap from 7 to 0 is reached.
// ---------------------------------------------------------------------------
module tb_wb_stage;

  localparam int CW = 3;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   rd1W, aluresultW, crd1W, pcW, immextW, pc_plus_4W, MemRW;
  logic          irqW;
  logic [2:0]    RegwriteDW;
  logic [1:0]    CSRWriteDW;
  logic [4:0]    rdW;
  logic [11:0]   csr_addrW;
  logic          wb_stall;
  logic          rf_wen;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic          csr_wen;
  logic [11:0]   csr_waddr;
  logic [31:0]   csr_wdata;
  logic          mepc_wen;
  logic [31:0]   mepc_wdata;
  logic          mcause_wen;
  logic [31:0]   mcause_wdata;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          commit_valid;
  logic [31:0]   commit_pc;
  logic [CW-1:0] instret;

  wb_stage #(.MCAUSE_ECALL(32'd11), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rd1W(rd1W), .aluresultW(aluresultW), .crd1W(crd1W), .pcW(pcW),
    .immextW(immextW), .pc_plus_4W(pc_plus_4W), .MemRW(MemRW),
    .irqW(irqW), .RegwriteDW(RegwriteDW), .CSRWriteDW(CSRWriteDW),
    .rdW(rdW), .csr_addrW(csr_addrW), .wb_stall(wb_stall),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .mepc_wen(mepc_wen), .mepc_wdata(mepc_wdata),
    .mcause_wen(mcause_wen), .mcause_wdata(mcause_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rf_wen;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;
    logic          csr_wen;
    logic [11:0]   csr_waddr;
    logic [31:0]   csr_wdata;
    logic          irq;
    logic [31:0]   pc;
    logic [31:0]   mtvec;
    logic [CW-1:0] instret;
  } exp_t;

  exp_t          sb_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  logic [CW-1:0] exp_cnt  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one bundle starting just after a rising edge; it is captured on the
  // next rising edge. track=0 sends an entry that is expected never to commit.
  task automatic send(input logic [2:0] rw, input logic [1:0] cw, input logic irq,
                      input logic [4:0] rd, input logic [11:0] ca,
                      input logic [31:0] rd1, input logic [31:0] alu,
                      input logic [31:0] crd1, input logic [31:0] pc,
                      input logic [31:0] imm, input logic [31:0] pc4,
                      input logic [31:0] memr,
                      input logic e_rf, input logic [31:0] e_rfd,
                      input logic e_csr, input logic [31:0] e_csrd,
                      input bit track);
    exp_t e;
    RegwriteDW = rw; CSRWriteDW = cw; irqW = irq; rdW = rd; csr_addrW = ca;
    rd1W = rd1; aluresultW = alu; crd1W = crd1; pcW = pc; immextW = imm;
    pc_plus_4W = pc4; MemRW = memr;
    if (track) begin
      e.rf_wen = e_rf;   e.rf_waddr = rd;   e.rf_wdata = e_rfd;
      e.csr_wen = e_csr; e.csr_waddr = ca;  e.csr_wdata = e_csrd;
      e.irq = irq;       e.pc = pc;         e.mtvec = crd1;
      e.instret = exp_cnt;
      exp_cnt = exp_cnt + 1'b1;
      sb_q.push_back(e);
    end
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (commit_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_commit", 32'(commit_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          $display("commit pc=%h instret=%0d rf_wen=%b rd=%0d data=%h csr_wen=%b mepc_wen=%b",
                   commit_pc, instret, rf_wen, rf_waddr, rf_wdata, csr_wen, mepc_wen);
          chk("commit_pc", commit_pc, e.pc);
          chk("instret", 32'(instret), 32'(e.instret));
          chk("rf_wen", 32'(rf_wen), 32'(e.rf_wen));
          if (e.rf_wen) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(e.rf_waddr));
            chk("rf_wdata", rf_wdata, e.rf_wdata);
          end
          chk("csr_wen", 32'(csr_wen), 32'(e.csr_wen));
          if (e.csr_wen) begin
            chk("csr_waddr", 32'(csr_waddr), 32'(e.csr_waddr));
            chk("csr_wdata", csr_wdata, e.csr_wdata);
          end
          chk("mepc_wen", 32'(mepc_wen), 32'(e.irq));
          chk("mcause_wen", 32'(mcause_wen), 32'(e.irq));
          chk("redirect_valid", 32'(redirect_valid), 32'(e.irq));
          if (e.irq) begin
            chk("mepc_wdata", mepc_wdata, e.pc);
            chk("mcause_wdata", mcause_wdata, 32'd11);
            chk("redirect_pc", redirect_pc, e.mtvec);
          end
        end
      end else begin
        chk("idle_enables",
            32'({rf_wen, csr_wen, mepc_wen, mcause_wen, redirect_valid}), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; wb_stall = 1'b0;
    rd1W = '0; aluresultW = '0; crd1W = '0; pcW = '0; immextW = '0;
    pc_plus_4W = '0; MemRW = '0; irqW = 1'b0; RegwriteDW = '0;
    CSRWriteDW = '0; rdW = '0; csr_addrW = '0;

    // Reset state
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_commit_valid", 32'(commit_valid), 32'd0);
    chk("rst_instret", 32'(instret), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_mcause_wdata", mcause_wdata, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Load write, x5 <- 0xDEADBEEF
    send(3'b010, 2'b00, 1'b0, 5'd5, 12'h000, 32'h1, 32'h11111111, 32'h2,
         32'h80000000, 32'h3, 32'h80000004, 32'hDEADBEEF,
         1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1);
    // ALU write to x0 is dropped but still commits
    send(3'b001, 2'b00, 1'b0, 5'd0, 12'h000, 32'h1, 32'h12345678, 32'h2,
         32'h80000004, 32'h3, 32'h80000008, 32'h4,
         1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    // Trap entry; its CSR mode is suppressed, its pc+4 GPR write still happens
    send(3'b011, 2'b01, 1'b1, 5'd1, 12'h305, 32'h5, 32'h6, 32'h80001000,
         32'h80000010, 32'h7, 32'h80000014, 32'h8,
         1'b1, 32'h80000014, 1'b0, 32'h0, 1'b1);
    // CSR write mode 01, GPR from crd1
    send(3'b101, 2'b01, 1'b0, 5'd7, 12'h300, 32'h000000F0, 32'h9, 32'h0000000F,
         32'h80000018, 32'hA, 32'h8000001C, 32'hB,
         1'b1, 32'h0000000F, 1'b1, 32'h000000F0, 1'b1);
    // CSR set mode 10, GPR from immediate into x31
    send(3'b100, 2'b10, 1'b0, 5'd31, 12'h341, 32'h00000F00, 32'hC, 32'h000000F0,
         32'h8000001C, 32'hABCD0000, 32'h80000020, 32'hD,
         1'b1, 32'hABCD0000, 1'b1, 32'h00000FF0, 1'b1);

    // Stall for three cycles, then a single commit
    send(3'b001, 2'b00, 1'b0, 5'd3, 12'h000, 32'h0, 32'hCAFEF00D, 32'h0,
         32'h80000040, 32'h0, 32'h80000044, 32'h0,
         1'b1, 32'hCAFEF00D, 1'b0, 32'h0, 1'b1);
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_no_commit", 32'(commit_valid), 32'd0);
      chk("stall_instret", 32'(instret), 32'd5);
    end
    @(posedge clk); #1;
    wb_stall = 1'b0;

    // Four back-to-back entries; counter passes 7 -> 0
    send(3'b110, 2'b00, 1'b0, 5'd2, 12'h000, 32'h0, 32'h1, 32'h0,
         32'h80000100, 32'h0, 32'h80000104, 32'h0,
         1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    send(3'b111, 2'b00, 1'b0, 5'd2, 12'h000, 32'h0, 32'h2, 32'h0,
         32'h80000104, 32'h0, 32'h80000108, 32'h0,
         1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    send(3'b000, 2'b11, 1'b0, 5'd2, 12'h300, 32'h3, 32'h3, 32'h0,
         32'h80000108, 32'h0, 32'h8000010C, 32'h0,
         1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    send(3'b001, 2'b00, 1'b0, 5'd4, 12'h000, 32'h0, 32'h00000004, 32'h0,
         32'h8000010C, 32'h0, 32'h80000110, 32'h0,
         1'b1, 32'h00000004, 1'b0, 32'h0, 1'b1);
    @(posedge clk); #1;
    chk("instret_wrapped", 32'(instret), 32'd2);

    // Reset while FULL: the entry is dropped without a clock edge
    send(3'b001, 2'b00, 1'b0, 5'd6, 12'h000, 32'h0, 32'h66666666, 32'h0,
         32'h80000200, 32'h0, 32'h80000204, 32'h0,
         1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("pre_reset_commit", 32'(commit_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_commit_valid", 32'(commit_valid), 32'd0);
    chk("async_rf_wen", 32'(rf_wen), 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd1);
    chk("async_instret", 32'(instret), 32'd0);
    chk("async_commit_pc", commit_pc, 32'd0);
    exp_cnt = '0;
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset_idle", 32'(commit_valid), 32'd0);
    end
    @(posedge clk); #1;

    // First entry after reset starts the count at 0
    send(3'b010, 2'b00, 1'b0, 5'd9, 12'h000, 32'h0, 32'h0, 32'h0,
         32'h80000300, 32'h0, 32'h80000304, 32'h55AA55AA,
         1'b1, 32'h55AA55AA, 1'b0, 32'h0, 1'b1);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
      @(posedge clk);
    end
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    @(posedge clk); #1;
    chk("final_instret", 32'(instret), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
